// File: rtl/shift_pkg.sv
// Shared types for the multi-cycle shift unit: operation encodings and FSM states.
package shift_pkg;

    typedef enum logic [1:0] {
        OP_SLL  = 2'b00,
        OP_SRL  = 2'b01,
        OP_SRA  = 2'b10,
        OP_RSVD = 2'b11   // executes as a logical right shift
    } shift_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } seq_state_t;

endpackage

// File: rtl/shift_step.sv
// One iteration of the shift datapath: a 1- or 2-bit left or right step.
// Left shifts fill with zero; right shifts fill with zero, except SRA which
// fills with the operand sign captured when the operation was accepted.
module shift_step
    import shift_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  shift_op_t    op,
    input  logic         sign,
    input  logic         by_two,
    output logic [N-1:0] y
);

    logic fill;

    // Select fill bit and shift direction/distance for this step
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        y    = a;
        fill = (op == OP_SRA) ? sign : 1'b0;
        if (op == OP_SLL) begin
            y = by_two ? {a[N-3:0], 2'b00} : {a[N-2:0], 1'b0};
        end else begin
            y = by_two ? {fill, fill, a[N-1:2]} : {fill, a[N-1:1]};
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle SLL/SRL/SRA unit for the EX stage. Accepts one operation through
// a valid/ready request port, steps the accumulator two bits per cycle (one bit
// for an odd remainder), and holds the result on the response port until taken.
// Flush aborts any in-flight operation without producing a response.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int N  = 32,
    parameter int SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [1:0]    req_op,
    input  logic [N-1:0]  req_a,
    input  logic [SW-1:0] req_shamt,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [N-1:0]  rsp_result,
    output logic          busy
);

    seq_state_t    state;
    logic [N-1:0]  acc;
    logic [SW-1:0] rem;
    shift_op_t     op;
    logic          sign;

    logic          by_two;
    logic [N-1:0]  step_y;

    // Two-bit steps while at least two positions remain; the odd bit goes last
    assign by_two = (rem >= SW'(2));

    shift_step #(.N(N)) u_step (
        .a      (acc),
        .op     (op),
        .sign   (sign),
        .by_two (by_two),
        .y      (step_y)
    );

    // Handshake and status decode from registered state; flush gates acceptance
    assign req_ready  = (state == ST_IDLE) && !flush;
    assign rsp_valid  = (state == ST_DONE);
    assign busy       = (state != ST_IDLE);
    assign rsp_result = acc;

    // Sequencer FSM with operand, remainder and sign registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            acc   <= '0;
            rem   <= '0;
            op    <= OP_SLL;
            sign  <= 1'b0;
        end else if (flush) begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        acc   <= req_a;
                        rem   <= req_shamt;
                        op    <= shift_op_t'(req_op);
                        sign  <= req_a[N-1];
                        state <= (req_shamt == '0) ? ST_DONE : ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    acc <= step_y;
                    if (by_two) begin
                        rem <= rem - SW'(2);
                        if (rem == SW'(2)) begin
                            state <= ST_DONE;
                        end
                    end else begin
                        rem   <= '0;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle shift unit for the EX stage of the pipelined RV32I core. It executes SLL/SRL/SRA (including the immediate forms) by iterating a 2-bit-per-step shift datapath rather than instantiating a full barrel shifter. The EX stage hands it one operation at a time through a valid/ready request port, stalls while it is `busy`, and collects the result through a valid/ready response port. The pipeline's `flush` aborts an in-flight operation.

## Interface
- `N`, default 32: datapath width; must be a power of two ≥ 4.
- `SW`, default `$clog2(N)`: shift-amount width.

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `flush`  in  1  synchronous abort from hazard unit.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request.
- `req_op`  in  2  shift type: 00 SLL, 01 SRL, 10 SRA, 11 reserved (executes as SRL).
- `req_a`  in  N  operand.
- `req_shamt`  in  SW  shift amount, 0..N-1.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer takes result.
- `rsp_result`  out  N  shifted value.
- `busy`  out  1  state ≠ IDLE; drives EX stall.

## Operation
- States: IDLE, SHIFT, DONE.
- `req_ready` = (state == IDLE) && !flush. Accept = `req_valid && req_ready`.
- On accept, latch `acc` ← `req_a`, `rem` ← `req_shamt`, `op` ← `req_op`, `sign` ← `req_a[N-1]`. Next state is DONE if `req_shamt` == 0, otherwise SHIFT.
- SHIFT step, one per cycle:
  - if `rem` ≥ 2: shift by 2 and set `rem` −= 2;
  - else shift by 1 and set `rem` ← 0.
  - When the step leaves `rem` == 0, the next state is DONE.
- Fill rules:
  - SLL fills the LSBs with 0.
  - SRL and op 11 fill the MSBs with 0.
  - SRA fills the MSBs with the latched `sign`, not with the current `acc[N-1]`.
- DONE: `rsp_valid` = 1 and `rsp_result` = `acc`. Both are held stable until `rsp_ready`. On `rsp_valid && rsp_ready`, the next state is IDLE. DONE does not accept a new request; there is no back-to-back bypass.
- `flush` has the highest priority over every other condition. From any state it forces IDLE on the next edge, drops the result without any response, and blocks acceptance in the same cycle. `acc` and `rem` are don't-care afterwards.
- Reset (asynchronous, any state):
  - state = IDLE, `acc` = 0, `rem` = 0, `op` = 00, `sign` = 0;
  - outputs: `rsp_valid` = 0, `busy` = 0, `rsp_result` = 0;
  - `req_ready` = 1 once `flush` is low.
- `rsp_result` = `acc` in every state; only DONE qualifies it as valid.

## Timing
- Request accepted at edge E0. `rsp_valid` is high in the cycle following edge E0 + ⌈shamt/2⌉.
  - shamt 0: `rsp_valid` the cycle after E0.
  - shamt 31: 16 SHIFT cycles.
- `busy` rises the cycle after E0 and falls the cycle after the response handshake.
- Occupancy = 1 + ⌈shamt/2⌉ + (cycles until `rsp_ready`) cycles. Minimum issue interval is 2 cycles for shamt 0 with `rsp_ready` tied high.
- `req_ready`, `rsp_valid` and `busy` are decoded from registered state only; `req_ready` additionally depends on `flush`. There are no combinational paths from `req_*` or `rsp_ready` to any output.
- Stepping of `rem` never underflows. The odd remainder is always consumed as the final 1-bit step.

## Structure
- Package `shift_pkg`:
  - `shift_op_t` (SLL/SRL/SRA/RSVD encodings);
  - `seq_state_t` (IDLE/SHIFT/DONE).
- Sub-module `shift_step`, combinational, parameter `N`:
  - inputs `a`, `op`, `sign`, `by_two`; output `y`;
  - implements one 1- or 2-bit left or right step with the fill rules above.
- `shift_sequencer` holds the FSM, `acc`, `rem`, `op`, `sign` and the handshake logic.

## Test plan
- SRL `0x80000000` by 31 → `0x00000001`; `rsp_valid` exactly 16 cycles after the accept edge; `busy` high throughout.
- SRA `0x80000000` by 5 → `0xFC000000` after 3 SHIFT cycles; SRA `0x40000000` by 5 → `0x02000000` (positive operand, no sign extension).
- SLL `0x00000001` by 0 → `0x00000001`, `rsp_valid` the cycle after accept; `req_op` 11 with `0xF0` by 4 → `0x0F`.
- SLL `0x00000003` by 30 → `0xC0000000`. Hold `rsp_ready` low for 5 cycles: `rsp_result` stable, `req_ready` 0, a second `req_valid` is not accepted; it is accepted after the handshake.
- `flush` in the 3rd SHIFT cycle of SRL by 20 → IDLE next cycle, `rsp_valid` never asserts, `req_valid` with `flush` high is not accepted; the next request completes correctly.
- Assert `rst` asynchronously mid-SHIFT → `busy`, `rsp_valid` and `rsp_result` go to 0 immediately without waiting for a clock edge; the first request after deassertion is correct.
